// File: rtl/reg_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_sched_pkg
// Purpose  : Opcode and FSM state encodings shared by the register scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package reg_sched_pkg;

    typedef enum logic [2:0] {
        OP_CLR  = 3'd0,
        OP_LOAD = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_SHR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_ADD  = 3'd6,
        OP_READ = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage : reg_sched_pkg
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
// Module   : register
// Purpose  : 4-bit multifunction register: clear, load, inc, dec, shifts.
// Revision : 1.0 - initial release
// ============================================================================
module register (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cl,
    input  logic       ld,
    input  logic       inc,
    input  logic       dec,
    input  logic       sr,
    input  logic       sl,
    input  logic       ir,
    input  logic       il,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] r_q;

    // Controls are mutually exclusive in normal use; the priority only
    // guards against misuse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 4'd0;
        end else if (cl) begin
            r_q <= 4'd0;
        end else if (ld) begin
            r_q <= d;
        end else if (inc) begin
            r_q <= r_q + 4'd1;
        end else if (dec) begin
            r_q <= r_q - 4'd1;
        end else if (sr) begin
            r_q <= {ir, r_q[3:1]};
        end else if (sl) begin
            r_q <= {r_q[2:0], il};
        end
    end

    assign q = r_q;

endmodule : register
`default_nettype wire

// File: rtl/reg_sched.sv
`default_nettype none
// ============================================================================
// Module   : reg_sched
// Purpose  : Round-robin two-requester command scheduler for a shared register.
// Revision : 1.0 - initial release
// ============================================================================
module reg_sched
    import reg_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [2:0] a_op,
    input  logic [3:0] a_arg,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [2:0] b_op,
    input  logic [3:0] b_arg,
    output logic       b_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_data,
    output logic       busy,
    output logic [3:0] value
);

    localparam logic [1:0] c_IDLE = ST_IDLE;
    localparam logic [1:0] c_EXEC = ST_EXEC;
    localparam logic [1:0] c_RESP = ST_RESP;

    logic [1:0] r_state;
    logic [2:0] r_op;
    logic [3:0] r_arg;
    logic [3:0] r_cnt;
    logic       r_id;
    logic       r_last;

    logic       w_accept;
    logic       w_gnt_id;
    logic [2:0] w_sel_op;
    logic [3:0] w_sel_arg;
    logic       w_exec_done;
    logic       w_cl, w_ld, w_inc, w_dec, w_sr, w_sl;

    // On a tie the requester not served last wins; r_last=1 means B was last.
    assign w_gnt_id  = (a_valid && b_valid) ? ~r_last : b_valid;
    assign w_accept  = (r_state == c_IDLE) && (a_valid || b_valid);
    assign a_ready   = w_accept && !w_gnt_id;
    assign b_ready   = w_accept &&  w_gnt_id;
    assign w_sel_op  = w_gnt_id ? b_op  : a_op;
    assign w_sel_arg = w_gnt_id ? b_arg : a_arg;

    // r_cnt holds the remaining ADD increments; ADD 0 and ADD 1 both finish at once.
    assign w_exec_done = (r_op != OP_ADD) || (r_cnt <= 4'd1);

    always_comb begin
        w_cl  = 1'b0;
        w_ld  = 1'b0;
        w_inc = 1'b0;
        w_dec = 1'b0;
        w_sr  = 1'b0;
        w_sl  = 1'b0;
        if (r_state == c_EXEC) begin
            case (r_op)
                OP_CLR:  w_cl  = 1'b1;
                OP_LOAD: w_ld  = 1'b1;
                OP_INC:  w_inc = 1'b1;
                OP_DEC:  w_dec = 1'b1;
                OP_SHR:  w_sr  = 1'b1;
                OP_SHL:  w_sl  = 1'b1;
                OP_ADD:  w_inc = (r_cnt != 4'd0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_op    <= 3'd0;
            r_arg   <= 4'd0;
            r_cnt   <= 4'd0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_sel_op;
                        r_arg   <= w_sel_arg;
                        r_cnt   <= w_sel_arg;
                        r_id    <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (w_exec_done) begin
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign rsp_valid = (r_state == c_RESP);
    assign rsp_id    = rsp_valid & r_id;
    assign rsp_data  = rsp_valid ? value : 4'd0;

    register u_register (
        .clk   (clk),
        .rst_n (rst_n),
        .cl    (w_cl),
        .ld    (w_ld),
        .inc   (w_inc),
        .dec   (w_dec),
        .sr    (w_sr),
        .sl    (w_sl),
        .ir    (r_arg[0]),
        .il    (r_arg[0]),
        .d     (r_arg),
        .q     (value)
    );

endmodule : reg_sched
`default_nettype wire

// File: tb/tb_reg_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_sched
// Purpose  : Directed scoreboard bench for reg_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_sched;
    import reg_sched_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       a_valid, b_valid;
    logic [2:0] a_op, b_op;
    logic [3:0] a_arg, b_arg;
    logic       a_ready, b_ready;
    logic       rsp_valid, rsp_id, busy;
    logic [3:0] rsp_data, value;

    reg_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_op      (a_op),
        .a_arg     (a_arg),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_op      (b_op),
        .b_arg     (b_arg),
        .b_ready   (b_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .value     (value)
    );

    typedef struct {
        bit         id;
        logic [3:0] data;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [3:0] m_val    = 4'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] model(input logic [2:0] op, input logic [3:0] arg,
                                         input logic [3:0] v);
        case (op)
            3'd0:    return 4'd0;
            3'd1:    return arg;
            3'd2:    return 4'(v + 4'd1);
            3'd3:    return 4'(v - 4'd1);
            3'd4:    return {arg[0], v[3:1]};
            3'd5:    return {v[2:0], arg[0]};
            3'd6:    return 4'(v + arg);
            default: return v;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [3:0] arg);
        return (op == 3'd6 && arg > 4'd1) ? 1 + int'(arg) : 2;
    endfunction

    // Response monitor: every pulse must match the oldest outstanding command.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id",   int'(rsp_id),   int'(e.id));
                    chk("rsp_data", int'(rsp_data), int'(e.data));
                    chk("rsp_cycle", cyc, e.due);
                end
            end else begin
                chk("rsp_idle_zero", int'({rsp_id, rsp_data}), 0);
            end
        end
    end

    function automatic exp_t mk(input bit id, input logic [2:0] op, input logic [3:0] arg);
        exp_t e;
        m_val  = model(op, arg, m_val);
        e.id   = id;
        e.data = m_val;
        e.due  = cyc + lat(op, arg);
        return e;
    endfunction

    task automatic issue(input bit side, input logic [2:0] op, input logic [3:0] arg,
                         input bit expect_rsp);
        @(negedge clk);
        if (side) begin b_valid = 1'b1; b_op = op; b_arg = arg; end
        else      begin a_valid = 1'b1; a_op = op; a_arg = arg; end
        #1;
        chk("grant_ready", int'({a_ready, b_ready}), side ? 1 : 2);
        if (expect_rsp) sb.push_back(mk(side, op, arg));
        @(posedge clk);
        #1;
        if (side) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) done = 1'b1;
            else if (busy) chk("ready_low_busy", int'({a_ready, b_ready}), 0);
        end
        if (!done) chk("wait_timeout", 1, 0);
    endtask

    // Both requesters valid together; 'first' names the expected winner.
    task automatic tie(input logic [2:0] aop, input logic [3:0] aarg,
                       input logic [2:0] bop, input logic [3:0] barg, input bit first);
        bit idle = 1'b0;
        @(negedge clk);
        a_valid = 1'b1; a_op = aop; a_arg = aarg;
        b_valid = 1'b1; b_op = bop; b_arg = barg;
        #1;
        chk("tie_first", int'({a_ready, b_ready}), first ? 1 : 2);
        if (first) sb.push_back(mk(1'b1, bop, barg));
        else       sb.push_back(mk(1'b0, aop, aarg));
        @(posedge clk);
        #1;
        if (first) b_valid = 1'b0; else a_valid = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            #1;
            if (!busy) idle = 1'b1;
            else chk("tie_wait_ready", int'({a_ready, b_ready}), 0);
        end
        chk("tie_second", int'({a_ready, b_ready}), first ? 2 : 1);
        if (first) sb.push_back(mk(1'b0, aop, aarg));
        else       sb.push_back(mk(1'b1, bop, barg));
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_done();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_val = 4'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_op = 3'd0; a_arg = 4'd0;
        b_valid = 1'b0; b_op = 3'd0; b_arg = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", int'({a_ready, b_ready}), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_value", int'(value), 0);
        chk("rst_rsp",   int'({rsp_valid, rsp_id, rsp_data}), 0);
        rst_n = 1'b1;

        issue(1'b0, OP_LOAD, 4'd5, 1'b1);
        wait_done();
        chk("load_value", int'(value), 5);

        do_reset();
        tie(OP_INC, 4'd0, OP_DEC, 4'd0, 1'b0);
        // B was served last, so the next tie goes to A.
        tie(OP_LOAD, 4'hE, OP_READ, 4'd0, 1'b0);
        chk("value_E", int'(value), 14);

        issue(1'b0, OP_ADD, 4'd3, 1'b1);
        wait_done();
        chk("add_wrap_value", int'(value), 1);

        issue(1'b0, OP_LOAD, 4'd6, 1'b1);
        wait_done();
        issue(1'b1, OP_SHR, 4'd1, 1'b1);
        // A command offered while busy and then withdrawn must not execute.
        a_valid = 1'b1; a_op = OP_CLR; a_arg = 4'd0;
        @(negedge clk);
        #1;
        chk("busy_ignore_ready", int'(a_ready), 0);
        a_valid = 1'b0;
        wait_done();
        chk("shr_value", int'(value), 11);
        issue(1'b0, OP_SHL, 4'd0, 1'b1);
        wait_done();
        chk("shl_value", int'(value), 6);

        issue(1'b0, OP_ADD, 4'd0, 1'b1);
        wait_done();
        chk("add0_value", int'(value), 6);
        issue(1'b0, OP_READ, 4'd9, 1'b1);
        wait_done();
        issue(1'b0, OP_ADD, 4'd1, 1'b1);
        wait_done();
        issue(1'b1, OP_DEC, 4'd0, 1'b1);
        wait_done();
        chk("dec_value", int'(value), 6);

        // Abort ADD 8 in its fourth EXEC cycle.
        issue(1'b0, OP_LOAD, 4'd3, 1'b1);
        wait_done();
        issue(1'b0, OP_ADD, 4'd8, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_pre_value", int'(value), 6);
        chk("abort_pre_busy", int'(busy), 1);
        a_valid = 1'b1; a_op = OP_READ; a_arg = 4'd0;
        rst_n = 1'b0;
        #1;
        chk("abort_value", int'(value), 0);
        chk("abort_busy",  int'(busy), 0);
        chk("abort_rsp",   int'(rsp_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_val = 4'd0;
        #1;
        chk("abort_reoffer", int'(a_ready), 1);
        sb.push_back(mk(1'b0, OP_READ, 4'd0));
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        wait_done();

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_sched
`default_nettype wire

// File: doc/reg_sched.md
REG_SCHED -- requirements
Module: reg_sched

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have a_valid  input  1  requester A command valid.
REQ-004 SHALL have a_op  input  3  requester A opcode.
REQ-005 SHALL have a_arg  input  4  requester A operand.
REQ-006 SHALL have a_ready  output  1  requester A command accepted this cycle.
REQ-007 SHALL have b_valid, b_op, b_arg, b_ready, identical to the A ports, for requester B.
REQ-008 SHALL have rsp_valid  output  1  one-cycle completion pulse.
REQ-009 SHALL have rsp_id  output  1  requester that owns the response: 0=A, 1=B.
REQ-010 SHALL have rsp_data  output  4  register value after the command.
REQ-011 SHALL have busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have value  output  4  live contents of the shared 4-bit register.

Function
REQ-013 SHALL implement the opcodes: 0 CLR, 1 LOAD arg, 2 INC, 3 DEC, 4 SHR with ir=arg[0], 5 SHL with il=arg[0], 6 ADD arg, 7 READ (no modification).
REQ-014 SHALL own one 4-bit multifunction register and drive exactly one of its controls per EXEC cycle (cl/ld/inc/dec/sr/sl), or none.
REQ-015 SHALL use a three-state FSM: IDLE -> EXEC -> RESP -> IDLE.
REQ-016 In IDLE with any valid asserted, SHALL grant exactly one requester, assert that requester's ready combinationally in the same cycle, latch op/arg/id, and move to EXEC.
REQ-017 Ready SHALL be low outside IDLE; a requester holding valid low SHALL never be granted.
REQ-018 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted most recently; when only one is valid, grant it.
REQ-019 Single-cycle ops (CLR/LOAD/INC/DEC/SHR/SHL/READ) SHALL spend exactly 1 cycle in EXEC.
REQ-020 ADD SHALL spend max(arg,1) cycles in EXEC, asserting inc in each of arg cycles; arg=0 SHALL give 1 EXEC cycle with no control asserted.
REQ-021 INC, DEC and ADD SHALL wrap modulo 16 (F+1=0, 0-1=F, E ADD 3 = 1).
REQ-022 RESP SHALL last exactly 1 cycle with rsp_valid=1, rsp_id=latched id, rsp_data=updated register value; there is no response backpressure.
REQ-023 Latency from accept cycle T: single-cycle op rsp_valid at T+2; ADD n (n>=1) rsp_valid at T+1+n.
REQ-024 SHALL ignore requester inputs while not in IDLE; a command changed or withdrawn before being accepted SHALL have no effect.
REQ-025 When rsp_valid=0, rsp_id and rsp_data SHALL read 0.

Reset
REQ-026 On rst_n low, SHALL force state=IDLE, register=0, value=0, busy=0, rsp_valid=0, a_ready=b_ready=0 (while the inputs are deasserted), and set the round-robin pointer so that A wins the first tie.
REQ-027 Reset mid-EXEC or mid-RESP SHALL abort the command with no response issued; ready SHALL be re-offered on the first clock after release.

Structure
REQ-028 SHALL place the opcode constants/enum and the FSM state enum in a shared package reg_sched_pkg.
REQ-029 SHALL instantiate the existing 4-bit multifunction register module (register) as its single sub-module and hold the ADD repeat counter locally.

Verification
REQ-030 Reset, A LOAD 5 -> a_ready=1 at T, rsp_valid at T+2 with rsp_id=0, rsp_data=5.
REQ-031 Both valid in the same cycle after reset, A INC and B DEC -> A served first and B next; rsp_data is 1 and then 0.
REQ-032 value=E, A ADD 3 -> 3 EXEC cycles, rsp at T+4, rsp_data=1 (wraps).
REQ-033 value=6, B SHR arg=1 -> rsp_data=B; then A SHL arg=0 -> rsp_data=6.
REQ-034 A ADD 0 -> rsp at T+2 with value unchanged; A READ -> rsp_data equals value.
REQ-035 rst_n low during ADD 8 at the fourth EXEC cycle -> no rsp_valid, value=0, busy=0, a_ready=1 on the first cycle after release with a_valid high.
